// File: rtl/store_split_sequencer.sv
// -----------------------------------------------------------------------------
// store_split_sequencer
//
// Turns one CPU store request (SB/SH/SW at any byte address) into one or two
// word-aligned write beats with per-byte write masks. A store that runs past
// the end of its 32-bit word is split into a second beat at the next word
// address (wrapping modulo 2^ADDR_WIDTH). The pipeline is held off via
// req_ready while a request is in flight.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   req_valid  : store request present
//   req_ready  : block is idle and can accept a request
//   req_addr   : byte address of the store
//   req_op     : 2'b00 SB, 2'b01 SH, 2'b10 SW, 2'b11 invalid
//   req_data   : right-justified store data
//   mem_valid  : write beat present (registered)
//   mem_ready  : memory accepts the beat
//   mem_addr   : word-aligned beat address (registered)
//   mem_wdata  : lane-aligned write data, unmasked lanes are 0 (registered)
//   mem_wmask  : byte enables, bit i covers [8i+7:8i] (registered)
//   done       : pulse in the cycle after the last beat handshake
//   split      : pulse with done when the request needed two beats
//   err        : pulse in the cycle after accepting an invalid op
// -----------------------------------------------------------------------------
module store_split_sequencer #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_op,
    input  logic [31:0]           req_data,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wmask,
    output logic                  done,
    output logic                  split,
    output logic                  err
);

    localparam logic [1:0] STORE_OP_SB = 2'b00;
    localparam logic [1:0] STORE_OP_SH = 2'b01;
    localparam logic [1:0] STORE_OP_SW = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT0 = 2'b01,
        BEAT1 = 2'b10
    } state_t;

    state_t                  state_reg;
    logic                    mem_valid_reg;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic [31:0]             mem_wdata_reg;
    logic [3:0]              mem_wmask_reg;
    logic                    done_reg;
    logic                    split_reg;
    logic                    err_reg;
    // Upper half of the lane vector / shifted data, held for a possible beat 1.
    logic [2:0]              hi_mask_reg;
    logic [31:0]             hi_data_reg;

    logic [1:0]              offset;
    logic [3:0]              size_mask;
    logic                    op_valid;
    logic [31:0]             data_masked;
    logic [6:0]              lane_vec;
    logic [63:0]             shifted_data;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic                    accept;

    assign offset    = req_addr[1:0];
    assign base_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    assign accept    = req_valid && (state_reg == IDLE);

    always_comb begin
        size_mask = 4'b0000;
        op_valid  = 1'b1;
        case (req_op)
            STORE_OP_SB: size_mask = 4'b0001;
            STORE_OP_SH: size_mask = 4'b0011;
            STORE_OP_SW: size_mask = 4'b1111;
            default:     op_valid  = 1'b0;
        endcase
    end

    // Bytes beyond the access size are forced to zero so that lanes with a
    // cleared mask bit never carry stale upper bits of req_data.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_mask
            assign data_masked[8*gi +: 8] = req_data[8*gi +: 8] & {8{size_mask[gi]}};
        end
    endgenerate

    assign lane_vec     = {3'b000, size_mask} << offset;
    assign shifted_data = {32'b0, data_masked} << {offset, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            mem_valid_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wmask_reg <= '0;
            done_reg      <= 1'b0;
            split_reg     <= 1'b0;
            err_reg       <= 1'b0;
            hi_mask_reg   <= '0;
            hi_data_reg   <= '0;
        end else begin
            done_reg  <= 1'b0;
            split_reg <= 1'b0;
            err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (op_valid) begin
                            state_reg     <= BEAT0;
                            mem_valid_reg <= 1'b1;
                            mem_addr_reg  <= base_addr;
                            mem_wmask_reg <= lane_vec[3:0];
                            mem_wdata_reg <= shifted_data[31:0];
                            hi_mask_reg   <= lane_vec[6:4];
                            hi_data_reg   <= shifted_data[63:32];
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ready) begin
                        if (hi_mask_reg != 3'b000) begin
                            // Next word; the add wraps naturally at the top of the space.
                            state_reg     <= BEAT1;
                            mem_addr_reg  <= mem_addr_reg + ADDR_WIDTH'(4);
                            mem_wmask_reg <= {1'b0, hi_mask_reg};
                            mem_wdata_reg <= hi_data_reg;
                        end else begin
                            state_reg     <= IDLE;
                            mem_valid_reg <= 1'b0;
                            mem_addr_reg  <= '0;
                            mem_wdata_reg <= '0;
                            mem_wmask_reg <= '0;
                            done_reg      <= 1'b1;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ready) begin
                        state_reg     <= IDLE;
                        mem_valid_reg <= 1'b0;
                        mem_addr_reg  <= '0;
                        mem_wdata_reg <= '0;
                        mem_wmask_reg <= '0;
                        done_reg      <= 1'b1;
                        split_reg     <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    mem_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign mem_valid = mem_valid_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wmask = mem_wmask_reg;
    assign done      = done_reg;
    assign split     = split_reg;
    assign err       = err_reg;

endmodule

// File: doc/store_split_sequencer.md
# store_split_sequencer

Sequences CPU store requests onto the word-wide data-memory write port. Each request is converted into one or two aligned write beats with per-byte write masks. Stores that cross a 32-bit word boundary (SH at offset 3, SW at offsets 1–3) are split into two consecutive beats. The block sits between the MEM-stage store path and the data-memory/bus interface, and it stalls the pipeline via `req_ready` while a request is in flight.

## Interface
- `ADDR_WIDTH`, 32, byte-address width of `req_addr`/`mem_addr`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: store request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_addr` in ADDR_WIDTH: byte address of the store.
- `req_op` in StoreOp_t: STORE_OP_SB / STORE_OP_SH / STORE_OP_SW; other encodings are invalid.
- `req_data` in 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `mem_valid` out 1: write beat present.
- `mem_ready` in 1: memory accepts the beat.
- `mem_addr` out ADDR_WIDTH: word-aligned beat address; bits [1:0] are always 0.
- `mem_wdata` out 32: lane-aligned write data.
- `mem_wmask` out 4: byte-enable per lane (bit i enables [8i+7:8i]).
- `done` out 1: one-cycle pulse when the last beat of a request completes.
- `split` out 1: one-cycle pulse, asserted with `done`, when the request used two beats.
- `err` out 1: one-cycle pulse, the cycle after accepting a request with an invalid `req_op`.

## Operation
- States: IDLE, BEAT0, BEAT1.
- `req_ready` = (state == IDLE). No combinational path from `req_valid` to `req_ready`.
- Accept occurs on `req_valid && req_ready`. On accept, register the address, op and data, and compute the following:
  - o = `req_addr[1:0]`.
  - n = 1, 2 or 4 for SB, SH or SW.
  - Lane vector L = ((1<<n)-1) << o, 7 bits wide.
  - Shifted data D = {32'b0, data} << (8*o), 64 bits wide.
  - Base word W = `req_addr` with [1:0] cleared.
- Beat 0: `mem_addr`=W, `mem_wmask`=L[3:0], `mem_wdata`=D[31:0].
- Beat 1 is needed only if L[6:4] ≠ 0. Its values are `mem_addr`=W+4 (modulo 2^ADDR_WIDTH, so 0xFFFFFFFC wraps to 0x0), `mem_wmask`={1'b0, L[6:4]}, `mem_wdata`=D[63:32].
- Transitions:
  - IDLE → BEAT0 on accept with a valid op.
  - IDLE → IDLE on accept with an invalid op. `err` pulses next cycle; no beat is issued and `done` is not pulsed.
  - BEAT0 → IDLE on `mem_ready` if no beat 1; `done` pulses.
  - BEAT0 → BEAT1 on `mem_ready` if beat 1 is needed.
  - BEAT1 → IDLE on `mem_ready`; `done` and `split` pulse.
- Data lanes with a mask bit of 0 are driven as 0, never X.
- `mem_valid` = (state ∈ {BEAT0, BEAT1}).

## Timing
- Reset values: state=IDLE, `req_ready`=1, `mem_valid`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wmask`=0, `done`=0, `split`=0, `err`=0.
- All mem_* outputs are registered.
- Latency:
  - Accept at edge N gives `mem_valid`=1 in cycle N+1.
  - An aligned store completes in 1 cycle plus beat wait states.
  - A split store takes a minimum of 2 beat cycles. Beat 1 is presented in the cycle after the beat-0 handshake.
- Beat stability: while `mem_valid`=1 and `mem_ready`=0, `mem_addr`, `mem_wdata` and `mem_wmask` hold constant. Once asserted, `mem_valid` is never withdrawn before the handshake except by reset.
- `done`/`split` are registered. They are high in the cycle after the final handshake edge, which is the same cycle `req_ready` returns to 1.
- Back-to-back: a new request may be accepted in the cycle `done` is high. Accept-to-accept minimum is 2 cycles for aligned stores and 3 for split stores.
- Reset mid-operation: an in-flight beat is abandoned. The next cycle shows `mem_valid`=0 and state=IDLE, and `done`/`split` are not pulsed. The abandoned beat may have been partially written if `mem_ready` coincided with `rst`; this is acceptable and the handshake is ignored.
- `req_*` inputs are sampled only at the accept edge. Changes at other times have no effect.

## Test plan
- Aligned SW: addr 0x100, data 0xDEADBEEF, `mem_ready`=1.
  - Expect one beat: addr 0x100, wdata 0xDEADBEEF, wmask 4'b1111.
  - Then `done`=1, `split`=0 in the cycle after the handshake.
- SB sweep: addr 0x200+o for o=0..3, data 0x000000A5.
  - Expect wmask 0001/0010/0100/1000 and wdata 0x000000A5/0x0000A500/0x00A50000/0xA5000000.
- Split SH: addr 0x303, data 0x1234.
  - Beat 0: addr 0x300, wmask 1000, wdata 0x34000000.
  - Beat 1: addr 0x304, wmask 0001, wdata 0x00000012.
  - `split`=1 with `done`.
- Split SW with backpressure: addr 0xFFFFFFFE, data 0xAABBCCDD, `mem_ready` low for 3 cycles on each beat.
  - Beat 0: addr 0xFFFFFFFC, wmask 1100, wdata 0xCCDD0000, held stable while stalled.
  - Beat 1: addr 0x00000000, wmask 0011, wdata 0x0000AABB.
  - `req_ready`=0 throughout.
- Invalid op: `req_op` set to an undefined encoding.
  - Expect no `mem_valid`, `err` pulse for 1 cycle, `req_ready` back to 1 the next cycle.
- Reset mid-split: assert `rst` while in BEAT1 with `mem_ready`=0.
  - Next cycle: `mem_valid`=0, `req_ready`=1, all outputs at reset values, no `done`.
  - A following aligned SW completes normally.
